// File: rtl/tqvp_rejunity_psg_multi.sv
// Multi-channel square-wave PSG with shared noise, prescaler, readback and PWM DAC output.
// Define PSG_NOISE_EN to build the noise LFSR, noise counter and register C.
module tqvp_rejunity_psg_multi #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned TONE_W   = 12,
  parameter int unsigned VOL_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);
  localparam int unsigned HI_W  = TONE_W - 8;
  localparam int unsigned SUM_W = VOL_W + $clog2((CHANNELS > 2) ? CHANNELS : 2);

  logic [7:0]          per_lo_q [CHANNELS];
  logic [HI_W-1:0]     per_hi_q [CHANNELS];
  logic [VOL_W-1:0]    vol_q    [CHANNELS];
  logic [CHANNELS-1:0] tone_en_q;
  logic [CHANNELS-1:0] noise_en_q;
  logic [1:0]          sel_q;
  logic                en_q;

  logic [9:0]          pre_q, pre_d, pre_max;
  logic                tick;
  logic [TONE_W-1:0]   per      [CHANNELS];
  logic [TONE_W-1:0]   tlast    [CHANNELS];
  logic [TONE_W-1:0]   tcnt_q   [CHANNELS];
  logic [TONE_W-1:0]   tcnt_d   [CHANNELS];
  logic [CHANNELS-1:0] sq_q, sq_d;
  logic [CHANNELS-1:0] gate, gate_q;
  logic [3:0]          gate_pad;
  logic [SUM_W-1:0]    sum_d, sum_q;
  logic [SUM_W-1:0]    pwm_cnt_d, pwm_cnt_q;
  logic                pwm_d, pwm_q;
  logic                noise;
  logic                wr_sel, wr_ctrl, soft_rst;
  logic                unused_ui;

  assign unused_ui = ^ui_in;

  assign wr_sel   = data_write && (address == 4'hD);
  assign wr_ctrl  = data_write && (address == 4'hF);
  assign soft_rst = wr_ctrl && data_in[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        per_lo_q[c] <= '0;
        per_hi_q[c] <= '0;
        vol_q[c]    <= '0;
      end
      tone_en_q  <= '0;
      noise_en_q <= '0;
      sel_q      <= 2'd2;
      en_q       <= 1'b1;
    end else if (data_write) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (address == 4'(2 * c))     per_lo_q[c] <= data_in;
        if (address == 4'(2 * c + 1)) per_hi_q[c] <= data_in[HI_W-1:0];
        if (address == 4'(8 + c)) begin
          vol_q[c]      <= data_in[VOL_W-1:0];
          tone_en_q[c]  <= data_in[6];
          noise_en_q[c] <= data_in[7];
        end
      end
      if (address == 4'hD) sel_q <= data_in[1:0];
      if (address == 4'hF) en_q  <= data_in[0];
    end
  end

  always_comb begin
    case (sel_q)
      2'd0:    pre_max = 10'd15;
      2'd1:    pre_max = 10'd63;
      2'd2:    pre_max = 10'd255;
      default: pre_max = 10'd1023;
    endcase
  end

  assign tick = en_q && (pre_q >= pre_max);

  always_comb begin
    pre_d = pre_q;
    if (soft_rst || wr_sel) pre_d = '0;
    else if (en_q)          pre_d = tick ? '0 : pre_q + 10'd1;
  end

  // ">=" rather than "==" so a period shortened below the running count wraps on the next tick.
  always_comb begin
    tcnt_d = tcnt_q;
    sq_d   = sq_q;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      per[c]   = {per_hi_q[c], per_lo_q[c]};
      tlast[c] = (per[c] == '0) ? '0 : per[c] - TONE_W'(1);
      if (soft_rst) begin
        tcnt_d[c] = '0;
        sq_d[c]   = 1'b0;
      end else if (tick) begin
        if (tcnt_q[c] >= tlast[c]) begin
          tcnt_d[c] = '0;
          sq_d[c]   = ~sq_q[c];
        end else begin
          tcnt_d[c] = tcnt_q[c] + TONE_W'(1);
        end
      end
    end
  end

`ifdef PSG_NOISE_EN
  logic [4:0]  nper_q, ncnt_q, ncnt_d, nlast;
  logic [16:0] lfsr_q, lfsr_d;

  assign nlast = (nper_q == '0) ? '0 : nper_q - 5'd1;

  always_comb begin
    ncnt_d = ncnt_q;
    lfsr_d = lfsr_q;
    if (soft_rst) begin
      ncnt_d = '0;
      lfsr_d = 17'd1;
    end else if (tick) begin
      if (ncnt_q >= nlast) begin
        ncnt_d = '0;
        lfsr_d = {lfsr_q[15:0], lfsr_q[16] ^ lfsr_q[13]};
      end else begin
        ncnt_d = ncnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nper_q <= '0;
      ncnt_q <= '0;
      lfsr_q <= 17'd1;
    end else begin
      if (data_write && (address == 4'hC)) nper_q <= data_in[4:0];
      ncnt_q <= ncnt_d;
      lfsr_q <= lfsr_d;
    end
  end

  assign noise = lfsr_q[0];
`else
  assign noise = 1'b1;
`endif

  always_comb begin
    gate = '0;
    for (int unsigned c = 0; c < CHANNELS; c++)
      gate[c] = (sq_q[c] | ~tone_en_q[c]) & (noise | ~noise_en_q[c]);
  end

  always_comb begin
    sum_d = '0;
    for (int unsigned c = 0; c < CHANNELS; c++)
      if (gate_q[c]) sum_d = sum_d + SUM_W'(vol_q[c]);
  end

  assign pwm_cnt_d = en_q ? pwm_cnt_q + SUM_W'(1) : pwm_cnt_q;
  assign pwm_d     = en_q && (pwm_cnt_q < sum_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) tcnt_q[c] <= '0;
      sq_q      <= '0;
      gate_q    <= '0;
      sum_q     <= '0;
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      tcnt_q    <= tcnt_d;
      sq_q      <= sq_d;
      gate_q    <= gate;
      sum_q     <= sum_d;
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_d;
    end
  end

  always_comb begin
    gate_pad = '0;
    gate_pad[CHANNELS-1:0] = gate_q;
  end

  assign uo_out = {gate_pad, {4{pwm_q}}};

  always_comb begin
    data_out = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (address == 4'(2 * c))     data_out = per_lo_q[c];
      if (address == 4'(2 * c + 1)) data_out[HI_W-1:0] = per_hi_q[c];
      if (address == 4'(8 + c)) begin
        data_out[VOL_W-1:0] = vol_q[c];
        data_out[6]         = tone_en_q[c];
        data_out[7]         = noise_en_q[c];
      end
    end
    case (address)
`ifdef PSG_NOISE_EN
      4'hC:    data_out = {3'b000, nper_q};
`endif
      4'hD:    data_out = {6'b0, sel_q};
      4'hE:    data_out = {gate_pad, 3'b000, noise};
      4'hF:    data_out = {7'b0, en_q};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tqvp_rejunity_psg_multi.sv
// Directed bench for tqvp_rejunity_psg_multi: register readback table plus timed tone/noise/PWM sequences.
module tb_tqvp_rejunity_psg_multi;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ui_in, uo_out, data_in, data_out;
  logic [3:0] address;
  logic       data_write;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wd;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 18;
`ifdef PSG_NOISE_EN
  localparam logic [7:0] C_RD = 8'h1F;
`else
  localparam logic [7:0] C_RD = 8'h00;
`endif

  vec_t vecs [NV];

  tqvp_rejunity_psg_multi #(.CHANNELS(3), .TONE_W(12), .VOL_W(4)) dut (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out), .address(address),
    .data_write(data_write), .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address = a; data_in = d; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  // Returns the number of clock edges until uo_out[4] equals v (maxc on timeout).
  task automatic wait_g0(input logic v, input int maxc, output int n);
    n = 0;
    while (uo_out[4] !== v && n < maxc) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic count_pwm(output int hi);
    hi = 0;
    repeat (64) begin
      @(negedge clk);
      if (uo_out[3:0] == 4'hF) hi++;
    end
  endtask

  initial begin
    int n, chg, pw;
    logic [16:0] m;
    logic exp_nb;

    vecs[0]  = '{1'b0, 4'h0, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 4'h8, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 4'hB, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 4'hC, 8'h00, 8'h00};
    vecs[4]  = '{1'b0, 4'hD, 8'h00, 8'h02};
    vecs[5]  = '{1'b0, 4'hE, 8'h00, 8'h71};
    vecs[6]  = '{1'b0, 4'hF, 8'h00, 8'h01};
    vecs[7]  = '{1'b1, 4'h6, 8'hAA, 8'h00};
    vecs[8]  = '{1'b1, 4'h7, 8'hFF, 8'h00};
    vecs[9]  = '{1'b1, 4'hE, 8'hFF, 8'h71};
    vecs[10] = '{1'b1, 4'h1, 8'hFF, 8'h0F};
    vecs[11] = '{1'b1, 4'h0, 8'h5A, 8'h5A};
    vecs[12] = '{1'b1, 4'h9, 8'h45, 8'h45};
    vecs[13] = '{1'b1, 4'hA, 8'hFF, 8'hCF};
    vecs[14] = '{1'b1, 4'hB, 8'hFF, 8'h00};
    vecs[15] = '{1'b1, 4'hC, 8'hFF, C_RD};
    vecs[16] = '{1'b1, 4'hD, 8'hFF, 8'h03};
    vecs[17] = '{1'b1, 4'hF, 8'h03, 8'h01};

    rst = 1'b1; ui_in = '0; address = '0; data_in = '0; data_write = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_rd0", data_out, 8'h00);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    // All tone_en clear: every present gate is 1, pwm idle with zero volume.
    chk("idle_uo", uo_out, 8'h70);
    wr(4'hF, 8'h81);
    count_pwm(n);
    chk("idle_pwm", n, 0);

    for (int i = 0; i < NV; i++) begin
      address = vecs[i].addr; data_in = vecs[i].wd; data_write = vecs[i].we;
      @(negedge clk);
      data_write = 1'b0;
      #1;
      chk($sformatf("vec%0d_a%h", i, vecs[i].addr), data_out, vecs[i].exp);
    end
    @(negedge clk);

    address = 4'h1;
    #1 chk("pre_async_rd1", data_out, 8'h0F);
    #2 rst = 1'b1;
    #1 chk("async_rd1", data_out, 8'h00);
    chk("async_uo", uo_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    wr(4'h8, 8'h4F);
    @(negedge clk);
    chk("tone_low", uo_out[4], 1'b0);
    wait_g0(1'b1, 400, n);
    chk("first_tick", n, 255);
    wait_g0(1'b0, 400, n);
    chk("tick_period_sel2", n, 256);

    wr(4'hD, 8'h00);
    wr(4'h0, 8'h01);
    wr(4'hF, 8'h03);
    repeat (2) @(negedge clk);
    chk("srst_gate_low", uo_out[4], 1'b0);
    wait_g0(1'b1, 100, n);
    chk("tone_rise", n, 15);
    wait_g0(1'b0, 100, n);
    chk("tone_half_lo", n, 16);
    wait_g0(1'b1, 100, n);
    chk("tone_half_hi", n, 16);

    wr(4'hF, 8'h00);
    chg = 0; pw = 0;
    repeat (64) begin
      @(negedge clk);
      if (uo_out[4] !== 1'b1) chg++;
      if (uo_out[3:0] != 4'h0) pw++;
    end
    chk("freeze_gate", chg, 0);
    chk("freeze_pwm", pw, 0);
    wr(4'hF, 8'h01);

    wr(4'h8, 8'h0F);
    wr(4'h9, 8'h0F);
    wr(4'hA, 8'h00);
    repeat (6) @(negedge clk);
    count_pwm(n);
    chk("duty_30", n, 30);
    chk("static_gates", uo_out[7:4], 4'h7);
    wr(4'hF, 8'h00);
    repeat (2) @(negedge clk);
    count_pwm(n);
    chk("disabled_pwm", n, 0);
    chk("disabled_gates", uo_out[7:4], 4'h7);
    wr(4'hF, 8'h01);

    wr(4'h8, 8'h4F);
    wr(4'h0, 8'h64);
    wr(4'hF, 8'h03);
    repeat (1284) @(negedge clk);
    chk("wrap_pre", uo_out[4], 1'b0);
    wr(4'h0, 8'h10);
    wait_g0(1'b1, 300, n);
    chk("wrap_next_tick", n, 12);
    wait_g0(1'b0, 300, n);
    chk("wrap_then_16", n, 256);

    wr(4'hC, 8'h00);
    wr(4'hF, 8'h03);
    address = 4'hE;
    m = 17'd1;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
`ifdef PSG_NOISE_EN
      exp_nb = m[0];
`else
      exp_nb = 1'b1;
`endif
      chk($sformatf("noise_k%0d", k), data_out[0], exp_nb);
      m = {m[15:0], m[16] ^ m[13]};
      repeat (16) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
